// File: rtl/adc_scan_scheduler_pkg.sv
// Shared types and helpers for the ADC scan scheduler: FSM state encoding,
// default channel geometry and the circular next-set-bit search.
package adc_scan_pkg;

    localparam int N_CH_DEF = 13;
    localparam int CH_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        REQ       = 2'd2,
        DONE      = 2'd3
    } scan_state_t;

    // First set bit strictly after cur (below n), wrapping; returns cur if none other is set.
    function automatic int next_set(logic [31:0] mask, int cur, int n);
        int   res;
        logic found;
        res   = cur;
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (!found && i > cur && i < n && mask[i[4:0]]) begin
                res   = i;
                found = 1'b1;
            end
        end
        for (int i = 0; i < 32; i++) begin
            if (!found && i <= cur && i < n && mask[i[4:0]]) begin
                res   = i;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/adc_scan_scheduler_if.sv
// Reader handshake (rd_*) and display-path sample strobe (smp_*, frame_done).
interface adc_scan_scheduler_if
    import adc_scan_pkg::*;
#(
    parameter int CH_W   = CH_W_DEF,
    parameter int DATA_W = 12
);
    logic              rd_req;
    logic [CH_W-1:0]   rd_ch;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              smp_valid;
    logic [CH_W-1:0]   smp_ch;
    logic [DATA_W-1:0] smp_data;
    logic              frame_done;

    modport master (
        output rd_req, rd_ch, smp_valid, smp_ch, smp_data, frame_done,
        input  rd_ack, rd_data
    );

    modport slave (
        input  rd_req, rd_ch, smp_valid, smp_ch, smp_data, frame_done,
        output rd_ack, rd_data
    );
endinterface

// File: rtl/adc_scan_scheduler_tick_divider.sv
// Scan-rate prescaler: counts 0..PRESC_M-1 while enabled, tick on the last count.
module tick_divider #(
    parameter int PRESC_W = 17,
    parameter int PRESC_M = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(PRESC_M - 1);

    logic [PRESC_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + PRESC_W'(1);
        end
    end

    assign tick = en && (count == LAST);
endmodule

// File: rtl/adc_scan_scheduler.sv
// Round-robin ADC scan scheduler: one read request per prescaler tick, results
// forwarded as sample strobes. Optional channel mask via ADC_SCAN_CH_MASK_EN.
//
// state     | meaning
// IDLE      | scanning disabled
// WAIT_TICK | armed, waiting for the next prescaler tick
// REQ       | rd_req held for the current channel until rd_ack
// DONE      | one-cycle sample strobe, pointer already advanced
module adc_scan_scheduler
    import adc_scan_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int CH_W    = CH_W_DEF,
    parameter int DATA_W  = 12,
    parameter int PRESC_W = 17,
    parameter int PRESC_M = 100000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
`ifdef ADC_SCAN_CH_MASK_EN
    input  logic [N_CH-1:0]        ch_mask,
`endif
    adc_scan_scheduler_if.master   bus,
    output logic                   overrun
);
    logic            tick;
    logic [31:0]     mask_ext;
    scan_state_t     state;
    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] ptr_next;
    logic [CH_W-1:0] req_ch;
    logic            ptr_en;
    logic            wrap;

    tick_divider #(
        .PRESC_W (PRESC_W),
        .PRESC_M (PRESC_M)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (enable),
        .tick  (tick)
    );

`ifdef ADC_SCAN_CH_MASK_EN
    assign mask_ext = 32'(ch_mask);
`else
    localparam logic [N_CH-1:0] ALL_CH = '1;
    assign mask_ext = 32'(ALL_CH);
`endif

    // A disabled current channel is skipped before the request is launched.
    always_comb begin
        ptr_en   = |(mask_ext & (32'd1 << ptr));
        ptr_next = CH_W'(next_set(mask_ext, int'(ptr), N_CH));
        req_ch   = ptr_en ? ptr : ptr_next;
        wrap     = (ptr_next <= ptr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ptr            <= '0;
            overrun        <= 1'b0;
            bus.rd_req     <= 1'b0;
            bus.rd_ch      <= '0;
            bus.smp_valid  <= 1'b0;
            bus.smp_ch     <= '0;
            bus.smp_data   <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.smp_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) state <= WAIT_TICK;
                end
                WAIT_TICK: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (tick && (mask_ext != '0)) begin
                        ptr        <= req_ch;
                        bus.rd_req <= 1'b1;
                        bus.rd_ch  <= req_ch;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (tick) overrun <= 1'b1;
                    if (bus.rd_ack) begin
                        bus.rd_req     <= 1'b0;
                        bus.smp_valid  <= 1'b1;
                        bus.smp_ch     <= ptr;
                        bus.smp_data   <= bus.rd_data;
                        bus.frame_done <= wrap;
                        ptr            <= ptr_next;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    if (tick) overrun <= 1'b1;
                    state <= enable ? WAIT_TICK : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Randomized scoreboard bench for adc_scan_scheduler (N_CH=3, PRESC_M=4).
module tb_adc_scan_scheduler;
    localparam int N_CH    = 3;
    localparam int CH_W    = 4;
    localparam int DATA_W  = 12;
    localparam int PRESC_W = 17;
    localparam int PRESC_M = 4;
    localparam int NEVER   = 1 << 30;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic overrun;
`ifdef ADC_SCAN_CH_MASK_EN
    logic [N_CH-1:0] ch_mask = 3'b111;
`endif

    adc_scan_scheduler_if #(.CH_W(CH_W), .DATA_W(DATA_W)) bus();

    adc_scan_scheduler #(
        .N_CH    (N_CH),
        .CH_W    (CH_W),
        .DATA_W  (DATA_W),
        .PRESC_W (PRESC_W),
        .PRESC_M (PRESC_M)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
`ifdef ADC_SCAN_CH_MASK_EN
        .ch_mask (ch_mask),
`endif
        .bus     (bus),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int ch;
        int data;
        int frame;
        int due;
    } smp_t;

    smp_t sq[$];
    int   nvec = 0;
    int   nfail = 0;

    // Reference model: scan position, sticky overrun, tick timeline
    int       m_ptr = 0;
    bit       m_ovr = 1'b0;
    int       m_e = 0;
    int       m_en_end = NEVER;
    int       m_ready = 0;
    bit [2:0] m_mask = 3'b111;

    task automatic chk(string name, int act, int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit ch_on(int c);
        return ((m_mask >> c) & 3'b001) != 3'b000;
    endfunction

    function automatic int next_after(int p);
        for (int i = 1; i <= N_CH; i++) begin
            if (ch_on((p + i) % N_CH)) return (p + i) % N_CH;
        end
        return p;
    endfunction

    function automatic int next_tick(int from);
        for (int c = from; c < from + 2 * PRESC_M; c++) begin
            if (c >= m_e && (c - m_e) % PRESC_M == PRESC_M - 1) return c;
        end
        return -1;
    endfunction

    function automatic bit tick_in(int lo, int hi);
        for (int c = lo; c <= hi; c++) begin
            if (c >= m_e && c < m_en_end && (c - m_e) % PRESC_M == PRESC_M - 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic wait_req(output int r, output bit ok);
        r  = -1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.rd_req) begin
                r  = cyc;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic enable_on();
        @(posedge clk); #1;
        enable   = 1'b1;
        m_e      = cyc;
        m_en_end = NEVER;
        m_ready  = cyc + 1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset  = 1'b1;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_ptr = 0;
        m_ovr = 1'b0;
    endtask

    // One request/ack exchange, ack d cycles after rd_req is first seen.
    task automatic txn(int d, bit drop_en, bit force_abc);
        int r, a, exp_req, ch, nxt, data;
        bit ok;
        exp_req = next_tick(m_ready) + 1;
        ch      = ch_on(m_ptr) ? m_ptr : next_after(m_ptr);
        wait_req(r, ok);
        if (!ok) begin
            nvec++;
            nfail++;
            $display("FAIL req_timeout: no rd_req seen, expected at cycle %0d", exp_req);
            return;
        end
        chk("req_cycle", r, exp_req);
        chk("rd_ch", int'(bus.rd_ch), ch);
        chk("overrun", int'(overrun), int'(m_ovr));
        for (int k = 1; k < d; k++) begin
            @(posedge clk); #1;
            if (k == 1 && drop_en) begin
                enable   = 1'b0;
                m_en_end = cyc;
            end
            @(negedge clk);
            chk("req_hold", int'(bus.rd_req), 1);
            chk("ch_hold", int'(bus.rd_ch), ch);
        end
        @(posedge clk); #1;
        data = (force_abc && ch == 1) ? 'hABC : int'($urandom_range(0, 4095));
        bus.rd_ack  = 1'b1;
        bus.rd_data = DATA_W'(data);
        a   = cyc;
        nxt = next_after(ch);
        sq.push_back('{ch, data, int'(nxt <= ch), a + 1});
        m_ptr   = nxt;
        m_ovr   = m_ovr | tick_in(r, a + 1);
        m_ready = a + 2;
        @(posedge clk); #1;
        bus.rd_ack = 1'b0;
    endtask

    initial begin : monitor
        smp_t s;
        forever begin
            @(negedge clk);
            if (bus.smp_valid) begin
                if (sq.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL smp_unexpected: smp_valid=1 ch=%0d, expected no strobe (cycle %0d)",
                             bus.smp_ch, cyc);
                end else begin
                    s = sq.pop_front();
                    chk("smp_cycle", cyc, s.due);
                    chk("smp_ch", int'(bus.smp_ch), s.ch);
                    chk("smp_data", int'(bus.smp_data), s.data);
                    chk("frame_done", int'(bus.frame_done), s.frame);
                end
            end else begin
                chk("frame_idle", int'(bus.frame_done), 0);
                if (sq.size() > 0 && sq[0].due < cyc) begin
                    s = sq.pop_front();
                    nvec++;
                    nfail++;
                    $display("FAIL smp_missing: no strobe for ch %0d, expected at cycle %0d", s.ch, s.due);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int  r, n_req;
        bit  ok;
        bus.rd_ack  = 1'b0;
        bus.rd_data = '0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_rd_req", int'(bus.rd_req), 0);
        chk("rst_rd_ch", int'(bus.rd_ch), 0);
        chk("rst_smp_valid", int'(bus.smp_valid), 0);
        chk("rst_smp_ch", int'(bus.smp_ch), 0);
        chk("rst_smp_data", int'(bus.smp_data), 0);
        chk("rst_frame", int'(bus.frame_done), 0);
        chk("rst_overrun", int'(overrun), 0);

        // Basic sequence 0,1,2,0 with ack after 2 cycles; ch1 carries 12'hABC
        enable_on();
        repeat (4) txn(2, 1'b0, 1'b1);
        repeat (6) txn(int'($urandom_range(1, 6)), 1'b0, 1'b0);

        // Long-stalled ack
        txn(10, 1'b0, 1'b0);

        // enable drops while the request is outstanding
        txn(3, 1'b1, 1'b0);
        n_req = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rd_req) n_req++;
        end
        chk("no_req_after_disable", n_req, 0);
        chk("presc_idle", int'(dut.u_tick.count), 0);

        // Reset in REQ, late ack one cycle after release
        enable_on();
        wait_req(r, ok);
        chk("pre_rst_req_seen", int'(ok), 1);
        chk("pre_rst_ch", int'(bus.rd_ch), ch_on(m_ptr) ? m_ptr : next_after(m_ptr));
        @(posedge clk); #1;
        reset  = 1'b1;
        enable = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_req_drop", int'(bus.rd_req), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        m_ptr = 0;
        m_ovr = 1'b0;
        @(posedge clk); #1;
        bus.rd_ack  = 1'b1;
        bus.rd_data = DATA_W'($urandom_range(0, 4095));
        @(posedge clk); #1;
        bus.rd_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_req", int'(bus.rd_req), 0);
        chk("late_ack_smp", int'(bus.smp_valid), 0);
        chk("rst_clears_ovr", int'(overrun), 0);
        repeat (3) @(negedge clk);
        enable_on();
        repeat (3) txn(int'($urandom_range(1, 4)), 1'b0, 1'b0);

`ifdef ADC_SCAN_CH_MASK_EN
        // Masked scan 0,2,0,2 then an all-zero mask
        do_reset();
        m_mask  = 3'b101;
        ch_mask = 3'b101;
        repeat (2) @(negedge clk);
        enable_on();
        repeat (4) txn(1, 1'b0, 1'b0);
        @(posedge clk); #1;
        m_mask  = 3'b000;
        ch_mask = 3'b000;
        n_req = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rd_req) n_req++;
        end
        chk("mask0_no_req", n_req, 0);
        chk("mask0_overrun", int'(overrun), 0);
        enable = 1'b0;
`endif

        repeat (5) @(negedge clk);
        chk("queue_empty", sq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
